// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter with a registered bus driver. Optional multi-beat
// bus locking with a beat timeout is built only when BUS_ARB_LOCK_EN is defined.
module bus_arbiter_rr #(
    parameter int WIDTH    = 32,
    parameter int NSRC     = 8,
    parameter int MAX_LOCK = 16,
    parameter int SELW     = $clog2(NSRC)
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [NSRC-1:0]       req,
    input  logic [NSRC-1:0]       lock,
    input  logic [NSRC*WIDTH-1:0] src_data,
    output logic [NSRC-1:0]       grant,
    output logic [SELW-1:0]       grant_idx,
    output logic                  bus_valid,
    output logic [WIDTH-1:0]      bus_data,
    output logic                  lock_timeout
);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_LOCKED} state_t;

    state_t          r_state;
    logic [SELW-1:0] r_ptr;

    logic            w_any;
    logic [SELW-1:0] w_win;
    logic [SELW-1:0] w_next_ptr;
    logic [WIDTH-1:0] w_win_data;

    // Search from the pointer upward, wrapping modulo NSRC without ever forming an index >= NSRC.
    always_comb begin
        int pos;
        w_any = 1'b0;
        w_win = '0;
        pos   = 0;
        for (int k = 0; k < NSRC; k++) begin
            pos = int'(r_ptr) + k;
            if (pos >= NSRC) begin
                pos = pos - NSRC;
            end
            if (!w_any && req[pos]) begin
                w_any = 1'b1;
                w_win = SELW'(pos);
            end
        end
    end

    assign w_next_ptr = (w_win == SELW'(NSRC - 1)) ? '0 : w_win + SELW'(1);
    assign w_win_data = src_data[int'(w_win)*WIDTH +: WIDTH];

`ifdef BUS_ARB_LOCK_EN
    localparam int CNTW = $clog2(MAX_LOCK + 1);

    logic [SELW-1:0]  r_owner;
    logic [CNTW-1:0]  r_cnt;
    logic             w_own_act;
    logic             w_hold;
    logic             w_expire;
    logic [WIDTH-1:0] w_own_data;

    assign w_own_act  = (r_state == S_LOCKED) && req[r_owner] && lock[r_owner];
    assign w_hold     = w_own_act && (r_cnt < CNTW'(MAX_LOCK));
    assign w_expire   = w_own_act && !w_hold;
    assign w_own_data = src_data[int'(r_owner)*WIDTH +: WIDTH];
`else
    logic w_unused_bits;
    assign w_unused_bits = ^{lock, r_state};
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            grant        <= '0;
            grant_idx    <= '0;
            bus_valid    <= 1'b0;
            bus_data     <= '0;
            lock_timeout <= 1'b0;
`ifdef BUS_ARB_LOCK_EN
            r_owner      <= '0;
            r_cnt        <= '0;
`endif
        end else begin
            lock_timeout <= 1'b0;
`ifdef BUS_ARB_LOCK_EN
            if (w_hold) begin
                // Locked owner keeps the bus; grant, index and pointer stay put.
                bus_data  <= w_own_data;
                bus_valid <= 1'b1;
                r_cnt     <= r_cnt + CNTW'(1);
            end else begin
                lock_timeout <= w_expire;
`endif
                if (w_any) begin
                    grant     <= NSRC'(1) << w_win;
                    grant_idx <= w_win;
                    bus_data  <= w_win_data;
                    bus_valid <= 1'b1;
                    r_ptr     <= w_next_ptr;
`ifdef BUS_ARB_LOCK_EN
                    r_owner   <= w_win;
                    r_cnt     <= CNTW'(1);
                    r_state   <= lock[w_win] ? S_LOCKED : S_GRANT;
`else
                    r_state   <= S_GRANT;
`endif
                end else begin
                    grant     <= '0;
                    bus_valid <= 1'b0;
                    r_state   <= S_IDLE;
                end
`ifdef BUS_ARB_LOCK_EN
            end
`endif
        end
    end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Scoreboard bench for bus_arbiter_rr: an 8-source instance and a 5-source
// instance with MAX_LOCK=4, driven with directed vectors.
module tb_bus_arbiter_rr;

    logic        clk = 1'b0;
    logic        clr = 1'b1;

    logic [7:0]   reqA = '0, lockA = '0;
    logic [255:0] srcA;
    logic [7:0]   grantA;
    logic [2:0]   idxA;
    logic         vldA, tmoA;
    logic [31:0]  dataA;

    logic [4:0]   reqB = '0, lockB = '0;
    logic [159:0] srcB;
    logic [4:0]   grantB;
    logic [2:0]   idxB;
    logic         vldB, tmoB;
    logic [31:0]  dataB;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          sel;
        bit          vld;
        int          idx;
        logic [31:0] data;
        bit          tmo;
    } exp_t;

    exp_t q[$];

`ifdef BUS_ARB_LOCK_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif

    bus_arbiter_rr #(.WIDTH(32), .NSRC(8), .MAX_LOCK(16)) u_a (
        .clk(clk), .clr(clr), .req(reqA), .lock(lockA), .src_data(srcA),
        .grant(grantA), .grant_idx(idxA), .bus_valid(vldA), .bus_data(dataA),
        .lock_timeout(tmoA)
    );

    bus_arbiter_rr #(.WIDTH(32), .NSRC(5), .MAX_LOCK(4)) u_b (
        .clk(clk), .clr(clr), .req(reqB), .lock(lockB), .src_data(srcB),
        .grant(grantB), .grant_idx(idxB), .bus_valid(vldB), .bus_data(dataB),
        .lock_timeout(tmoB)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] expA(input int i);
        return (i == 0) ? 32'hDEAD_BEEF : (32'hA0A0_0000 | 32'(i));
    endfunction

    function automatic logic [31:0] expB(input int i);
        return 32'hB0B0_0000 | 32'(i);
    endfunction

    initial begin
        for (int i = 0; i < 8; i++) srcA[i*32 +: 32] = expA(i);
        for (int i = 0; i < 5; i++) srcB[i*32 +: 32] = expB(i);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic stepA(input logic [7:0] r, input logic [7:0] l, input bit v, input int idx, input bit t);
        exp_t e;
        @(negedge clk);
        reqA = r;
        lockA = l;
        e.sel = 1'b0; e.vld = v; e.idx = idx; e.data = expA(idx); e.tmo = t;
        q.push_back(e);
    endtask

    task automatic stepB(input logic [4:0] r, input logic [4:0] l, input bit v, input int idx, input bit t);
        exp_t e;
        @(negedge clk);
        reqB = r;
        lockB = l;
        e.sel = 1'b1; e.vld = v; e.idx = idx; e.data = expB(idx); e.tmo = t;
        q.push_back(e);
    endtask

    // Monitor: one expected entry is consumed per clock, just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (!e.sel) begin
                    chk("A.bus_valid", 64'(vldA), 64'(e.vld));
                    chk("A.grant_idx", 64'(idxA), 64'(e.idx));
                    chk("A.grant", 64'(grantA), e.vld ? (64'd1 << e.idx) : 64'd0);
                    chk("A.bus_data", 64'(dataA), 64'(e.data));
                    chk("A.lock_timeout", 64'(tmoA), 64'(e.tmo));
                end else begin
                    chk("B.bus_valid", 64'(vldB), 64'(e.vld));
                    chk("B.grant_idx", 64'(idxB), 64'(e.idx));
                    chk("B.grant", 64'(grantB), e.vld ? (64'd1 << e.idx) : 64'd0);
                    chk("B.bus_data", 64'(dataB), 64'(e.data));
                    chk("B.lock_timeout", 64'(tmoB), 64'(e.tmo));
                end
            end
        end
    end

    initial begin
        int seqB_to [10];
        bit tmoB_to [10];

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst.grantA", 64'(grantA), 64'd0);
        chk("rst.idxA", 64'(idxA), 64'd0);
        chk("rst.vldA", 64'(vldA), 64'd0);
        chk("rst.dataA", 64'(dataA), 64'd0);
        chk("rst.tmoA", 64'(tmoA), 64'd0);
        chk("rst.vldB", 64'(vldB), 64'd0);
        @(negedge clk);
        clr = 1'b0;

        // Grant source 3, then reset asynchronously mid-cycle
        stepA(8'h08, 8'h00, 1'b1, 3, 1'b0);
        @(negedge clk);
        reqA = '0;
        clr = 1'b1;
        #1;
        chk("async.grantA", 64'(grantA), 64'd0);
        chk("async.idxA", 64'(idxA), 64'd0);
        chk("async.vldA", 64'(vldA), 64'd0);
        chk("async.dataA", 64'(dataA), 64'd0);
        chk("async.tmoA", 64'(tmoA), 64'd0);
        @(negedge clk);
        clr = 1'b0;

        stepA(8'h01, 8'h00, 1'b1, 0, 1'b0);
        stepA(8'h00, 8'h00, 1'b0, 0, 1'b0);

        // Round robin from pointer 0
        stepA(8'h80, 8'h00, 1'b1, 7, 1'b0);
        for (int i = 0; i < 10; i++) stepA(8'hFF, 8'h00, 1'b1, i % 8, 1'b0);

        // Wrap skip: source 5 then sparse requests
        stepA(8'h20, 8'h00, 1'b1, 5, 1'b0);
        stepA(8'h05, 8'h00, 1'b1, 0, 1'b0);
        stepA(8'h05, 8'h00, 1'b1, 2, 1'b0);

        // Lock source 3 for five beats, then release
        for (int i = 0; i < 5; i++) stepA(8'hFF, 8'h08, 1'b1, LOCK_ON ? 3 : 3 + i, 1'b0);
        stepA(8'hFF, 8'h00, 1'b1, LOCK_ON ? 4 : 0, 1'b0);
        stepA(8'h00, 8'h00, 1'b0, LOCK_ON ? 4 : 0, 1'b0);

        // Five-source round robin; lock bits are driven only when locking is absent
        for (int i = 0; i < 6; i++) stepB(5'h1F, LOCK_ON ? 5'h00 : 5'h1F, 1'b1, i % 5, 1'b0);

        // Timeout: source 1 holds req+lock, source 2 also requests
        if (LOCK_ON) begin
            seqB_to = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
            tmoB_to = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        end else begin
            seqB_to = '{1, 2, 1, 2, 1, 2, 1, 2, 1, 2};
            tmoB_to = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        end
        for (int i = 0; i < 10; i++) stepB(5'h06, 5'h02, 1'b1, seqB_to[i], tmoB_to[i]);
        stepB(5'h00, 5'h00, 1'b0, 2, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard.drained", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
